// File: rtl/pix_mem_pkg.sv
// Shared types and constants for the pixel memory read arbiter.
// Two 76800-word image banks form one flat address space.
package pix_mem_pkg;

    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 8;
    localparam int BANK_WORDS = 76800;
    localparam int MEM_DEPTH  = 2 * BANK_WORDS;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
    } rsp_tag_t;

endpackage

// File: rtl/rsp_tag_pipe.sv
// Fixed-depth shift register carrying response tags alongside the memory read latency.
// A reset flushes every in-flight tag.
module rsp_tag_pipe
    import pix_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  rsp_tag_t tag_in,
    output rsp_tag_t tag_out
);

    rsp_tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/pix_mem_read_arbiter.sv
// Round-robin arbiter sharing the pixel memory read port between scan-out (A) and readback (B).
// Responses return to their owner a fixed 1+RD_LAT cycles after acceptance.
module pix_mem_read_arbiter
    import pix_mem_pkg::*;
#(
    parameter int ADDR_W    = pix_mem_pkg::ADDR_W,
    parameter int DATA_W    = pix_mem_pkg::DATA_W,
    parameter int MEM_DEPTH = pix_mem_pkg::MEM_DEPTH,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic [ADDR_W-1:0] b_req_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_data,
    output logic              a_rsp_err,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_data,
    output logic              b_rsp_err
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

    owner_e            last_grant;
    logic              grant_a;
    logic              grant_b;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_in_range;
    rsp_tag_t          issue_tag;
    rsp_tag_t          tail_tag;
    logic              a_hit;
    logic              b_hit;
    logic [DATA_W-1:0] tail_data;
    logic [DATA_W-1:0] a_data_q;
    logic [DATA_W-1:0] b_data_q;

    // Handshake: a request transfers in any cycle where valid && ready; ready is a
    // combinational function of both valids and last_grant, at most one ready is high,
    // and a requester holds its address while valid && !ready.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (a_req_valid && (!b_req_valid || last_grant == OWN_B)) begin
                grant_a = 1'b1;
            end else if (b_req_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_req_ready  = grant_a;
    assign b_req_ready  = grant_b;
    assign grant_any    = grant_a | grant_b;
    assign sel_addr     = grant_b ? b_req_addr : a_req_addr;
    assign sel_in_range = {1'b0, sel_addr} < DEPTH_LIM;

    // Out-of-range grants still carry a tag so the requester gets an err response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_B;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            issue_tag  <= '0;
        end else begin
            mem_en <= grant_any && sel_in_range;
            if (grant_any && sel_in_range) begin
                mem_addr <= sel_addr;
            end
            issue_tag <= '{valid: grant_any,
                           owner: grant_b ? OWN_B : OWN_A,
                           err:   grant_any && !sel_in_range};
            if (grant_a) begin
                last_grant <= OWN_A;
            end else if (grant_b) begin
                last_grant <= OWN_B;
            end
        end
    end

    rsp_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rsp_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (issue_tag),
        .tag_out (tail_tag)
    );

    assign a_hit     = tail_tag.valid && (tail_tag.owner == OWN_A);
    assign b_hit     = tail_tag.valid && (tail_tag.owner == OWN_B);
    assign tail_data = tail_tag.err ? '0 : mem_rdata;

    // Data is passed through in the cycle it arrives and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            if (a_hit) begin
                a_data_q <= tail_data;
            end
            if (b_hit) begin
                b_data_q <= tail_data;
            end
        end
    end

    assign a_rsp_valid = a_hit;
    assign a_rsp_data  = a_hit ? tail_data : a_data_q;
    assign a_rsp_err   = a_hit && tail_tag.err;
    assign b_rsp_valid = b_hit;
    assign b_rsp_data  = b_hit ? tail_data : b_data_q;
    assign b_rsp_err   = b_hit && tail_tag.err;

endmodule

// File: tb/tb_pix_mem_read_arbiter.sv
// Directed and randomised checks of the arbiter at RD_LAT=1 and RD_LAT=3 driven in lockstep.
// Expected responses and memory strobes are queued at acceptance and popped as they appear.
module tb_pix_mem_read_arbiter;

    localparam int AW = 18;
    localparam int DW = 8;
    localparam int RW = 26;  // {due[15:0], port, err, data[7:0]}
    localparam int MW = 34;  // {due[15:0], addr[17:0]}
    localparam int LIMIT = 153600;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req_valid = 1'b0;
    logic [AW-1:0] a_req_addr = '0;
    logic          b_req_valid = 1'b0;
    logic [AW-1:0] b_req_addr = '0;

    logic          a_req_ready_1, b_req_ready_1, mem_en_1;
    logic [AW-1:0] mem_addr_1;
    logic [DW-1:0] mem_rdata_1;
    logic          a_rsp_valid_1, a_rsp_err_1, b_rsp_valid_1, b_rsp_err_1;
    logic [DW-1:0] a_rsp_data_1, b_rsp_data_1;

    logic          a_req_ready_3, b_req_ready_3, mem_en_3;
    logic [AW-1:0] mem_addr_3;
    logic [DW-1:0] mem_rdata_3;
    logic          a_rsp_valid_3, a_rsp_err_3, b_rsp_valid_3, b_rsp_err_3;
    logic [DW-1:0] a_rsp_data_3, b_rsp_data_3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic exp_last = 1'b1;  // 1 = B granted last

    logic [RW-1:0] rq1[$];
    logic [RW-1:0] rq3[$];
    logic [MW-1:0] mq1[$];
    logic [MW-1:0] mq3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pix_mem_read_arbiter #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready_1), .a_req_addr(a_req_addr),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready_1), .b_req_addr(b_req_addr),
        .mem_en(mem_en_1), .mem_addr(mem_addr_1), .mem_rdata(mem_rdata_1),
        .a_rsp_valid(a_rsp_valid_1), .a_rsp_data(a_rsp_data_1), .a_rsp_err(a_rsp_err_1),
        .b_rsp_valid(b_rsp_valid_1), .b_rsp_data(b_rsp_data_1), .b_rsp_err(b_rsp_err_1)
    );

    pix_mem_read_arbiter #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready_3), .a_req_addr(a_req_addr),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready_3), .b_req_addr(b_req_addr),
        .mem_en(mem_en_3), .mem_addr(mem_addr_3), .mem_rdata(mem_rdata_3),
        .a_rsp_valid(a_rsp_valid_3), .a_rsp_data(a_rsp_data_3), .a_rsp_err(a_rsp_err_3),
        .b_rsp_valid(b_rsp_valid_3), .b_rsp_data(b_rsp_data_3), .b_rsp_err(b_rsp_err_3)
    );

    // Memory models: data = addr[7:0], delivered RD_LAT cycles after the strobe.
    logic [AW:0] mp1 = '0;
    logic [AW:0] mp3 [3] = '{default: '0};
    always @(posedge clk) begin
        mp1    <= {mem_en_1, mem_addr_1};
        mp3[0] <= {mem_en_3, mem_addr_3};
        mp3[1] <= mp3[0];
        mp3[2] <= mp3[1];
    end
    assign mem_rdata_1 = mp1[AW] ? mp1[7:0] : 8'hEE;
    assign mem_rdata_3 = mp3[2][AW] ? mp3[2][7:0] : 8'hEE;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_rsp(input string tag, input logic has, input logic [RW-1:0] ent,
                           input logic av, input logic bv,
                           input logic [DW-1:0] ad, input logic [DW-1:0] bd,
                           input logic ae, input logic be, output logic pop);
        pop = 1'b0;
        if (av || bv) begin
            check({tag, "_one_hot"}, 32'(av && bv), 32'(0));
            if (!has) begin
                check({tag, "_unexpected_rsp"}, 32'(av || bv), 32'(0));
            end else begin
                pop = 1'b1;
                check({tag, "_due"}, 32'(cyc[15:0]), 32'(ent[RW-1 -: 16]));
                check({tag, "_port"}, 32'(bv), 32'(ent[9]));
                check({tag, "_data"}, 32'(bv ? bd : ad), 32'(ent[7:0]));
                check({tag, "_err"}, 32'(bv ? be : ae), 32'(ent[8]));
            end
        end else if (has && ent[RW-1 -: 16] <= cyc[15:0]) begin
            check({tag, "_missing_rsp"}, 32'(av || bv), 32'(1));
            pop = 1'b1;
        end
    endtask

    task automatic cmp_mem(input string tag, input logic has, input logic [MW-1:0] ent,
                           input logic en, input logic [AW-1:0] addr, output logic pop);
        pop = 1'b0;
        if (en) begin
            if (!has) begin
                check({tag, "_unexpected_mem_en"}, 32'(en), 32'(0));
            end else begin
                pop = 1'b1;
                check({tag, "_mem_due"}, 32'(cyc[15:0]), 32'(ent[MW-1 -: 16]));
                check({tag, "_mem_addr"}, 32'(addr), 32'(ent[AW-1:0]));
            end
        end else if (has && ent[MW-1 -: 16] <= cyc[15:0]) begin
            check({tag, "_missing_mem_en"}, 32'(en), 32'(1));
            pop = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        logic p;
        if (!rst) begin
            cmp_rsp("d1", rq1.size() > 0, rq1.size() > 0 ? rq1[0] : '0,
                    a_rsp_valid_1, b_rsp_valid_1, a_rsp_data_1, b_rsp_data_1,
                    a_rsp_err_1, b_rsp_err_1, p);
            if (p) void'(rq1.pop_front());
            cmp_rsp("d3", rq3.size() > 0, rq3.size() > 0 ? rq3[0] : '0,
                    a_rsp_valid_3, b_rsp_valid_3, a_rsp_data_3, b_rsp_data_3,
                    a_rsp_err_3, b_rsp_err_3, p);
            if (p) void'(rq3.pop_front());
            cmp_mem("d1", mq1.size() > 0, mq1.size() > 0 ? mq1[0] : '0, mem_en_1, mem_addr_1, p);
            if (p) void'(mq1.pop_front());
            cmp_mem("d3", mq3.size() > 0, mq3.size() > 0 ? mq3[0] : '0, mem_en_3, mem_addr_3, p);
            if (p) void'(mq3.pop_front());
        end
    end

    // Queue the expected strobe and response for a request accepted this cycle.
    task automatic push_exp(input logic port, input logic [AW-1:0] addr);
        logic          err;
        logic [DW-1:0] data;
        err  = (int'(addr) >= LIMIT);
        data = err ? 8'h00 : addr[7:0];
        rq1.push_back({16'(cyc + 2), port, err, data});
        rq3.push_back({16'(cyc + 4), port, err, data});
        if (!err) begin
            mq1.push_back({16'(cyc + 1), addr});
            mq3.push_back({16'(cyc + 1), addr});
        end
    endtask

    // One cycle: drive at the falling edge, check ready, queue expectations.
    task automatic step(input logic av, input logic [AW-1:0] aa,
                        input logic bv, input logic [AW-1:0] ba,
                        output logic ga, output logic gb);
        a_req_valid = av;
        a_req_addr  = aa;
        b_req_valid = bv;
        b_req_addr  = ba;
        #1;
        ga = av && (!bv || exp_last);
        gb = bv && !ga;
        check("a_ready_d1", 32'(a_req_ready_1), 32'(ga));
        check("b_ready_d1", 32'(b_req_ready_1), 32'(gb));
        check("a_ready_d3", 32'(a_req_ready_3), 32'(ga));
        check("b_ready_d3", 32'(b_req_ready_3), 32'(gb));
        if (ga) begin
            push_exp(1'b0, aa);
            exp_last = 1'b0;
        end else if (gb) begin
            push_exp(1'b1, ba);
            exp_last = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic          ga, gb, a_on, b_on;
        logic [AW-1:0] a_ad, b_ad;
        int            drain;

        // Reset: readies low even with both valids, all outputs cleared.
        repeat (2) @(negedge clk);
        a_req_valid = 1'b1;
        b_req_valid = 1'b1;
        #1;
        check("rst_a_ready", 32'(a_req_ready_1), 32'(0));
        check("rst_b_ready", 32'(b_req_ready_1), 32'(0));
        check("rst_a_ready_d3", 32'(a_req_ready_3), 32'(0));
        check("rst_b_ready_d3", 32'(b_req_ready_3), 32'(0));
        check("rst_mem_en", 32'(mem_en_1), 32'(0));
        check("rst_mem_addr", 32'(mem_addr_1), 32'(0));
        check("rst_a_rsp", 32'({a_rsp_valid_1, a_rsp_err_1, a_rsp_data_1}), 32'(0));
        check("rst_b_rsp", 32'({b_rsp_valid_1, b_rsp_err_1, b_rsp_data_1}), 32'(0));
        check("rst_d3_mem", 32'({mem_en_3, mem_addr_3}), 32'(0));
        check("rst_d3_rsp", 32'({a_rsp_valid_3, a_rsp_data_3, b_rsp_valid_3, b_rsp_data_3}), 32'(0));
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step(0, '0, 0, '0, ga, gb);

        // Reset mid-stream flushes in-flight requests.
        step(1, 18'd5, 1, 18'd6, ga, gb);
        step(1, 18'd5, 1, 18'd6, ga, gb);
        #2;
        rst = 1'b1;
        rq1.delete();
        rq3.delete();
        mq1.delete();
        mq3.delete();
        exp_last = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) step(0, '0, 0, '0, ga, gb);

        // A only, consecutive addresses.
        for (int i = 0; i < 3; i++) step(1, AW'(i), 0, '0, ga, gb);
        repeat (5) step(0, '0, 0, '0, ga, gb);
        check("a_data_hold", 32'(a_rsp_data_1), 32'(8'h02));
        check("b_data_idle", 32'(b_rsp_data_1), 32'(8'h00));

        // Sustained dual requests alternate; addresses held until granted.
        step(0, '0, 1, 18'd76700, ga, gb);
        a_ad = 18'd10;
        b_ad = 18'd76800;
        for (int i = 0; i < 6; i++) begin
            step(1, a_ad, 1, b_ad, ga, gb);
            check("alternate_grant_a", 32'(ga), 32'(i % 2 == 0));
            if (ga) a_ad = a_ad + 1'b1;
            if (gb) b_ad = b_ad + 1'b1;
        end

        // Out-of-range and top-of-range addresses.
        step(0, '0, 1, 18'd153600, ga, gb);
        step(1, 18'd153599, 0, '0, ga, gb);
        step(1, 18'd262143, 0, '0, ga, gb);
        step(0, '0, 0, '0, ga, gb);
        check("err_b_data_hold", 32'(b_rsp_data_1), 32'(8'h00));

        // Bank boundary and repeated address.
        step(1, 18'd76799, 0, '0, ga, gb);
        step(1, 18'd76800, 0, '0, ga, gb);
        step(1, 18'd7, 0, '0, ga, gb);
        step(1, 18'd7, 0, '0, ga, gb);

        // Random interleaved traffic obeying the hold rule.
        a_on = 1'b0;
        b_on = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!a_on && $urandom_range(0, 2) != 0) begin
                a_on = 1'b1;
                a_ad = AW'($urandom_range(0, 153700));
            end
            if (!b_on && $urandom_range(0, 2) != 0) begin
                b_on = 1'b1;
                b_ad = AW'($urandom_range(0, 153700));
            end
            step(a_on, a_ad, b_on, b_ad, ga, gb);
            if (ga) a_on = 1'b0;
            if (gb) b_on = 1'b0;
        end

        drain = 0;
        while ((rq1.size() + rq3.size() + mq1.size() + mq3.size()) > 0 && drain < 20) begin
            step(0, '0, 0, '0, ga, gb);
            drain++;
        end
        check("drain_rq1", 32'(rq1.size()), 32'(0));
        check("drain_rq3", 32'(rq3.size()), 32'(0));
        check("drain_mq1", 32'(mq1.size()), 32'(0));
        check("drain_mq3", 32'(mq3.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
